eeprom_cmd_seq: RTL and testbench

EEPROM_CMD_SEQ -- requirements
Module: eeprom_cmd_seq

---
 rtl/eeprom_pkg.sv | 38 +++
 rtl/eeprom_cmd_seq_if.sv | 26 ++
 rtl/sync_fifo.sv | 48 ++++
 rtl/eeprom_cmd_seq.sv | 131 +++++++++++++
 tb/tb_eeprom_cmd_seq.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eeprom_pkg.sv
// Shared types, op codes and defaults for the EEPROM command sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package eeprom_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_RELEASE  = 2'd2,
    ST_TWR_WAIT = 2'd3
  } state_t;

  // Start_Sig op codes presented to the I2C engine
  localparam logic [1:0] OP_IDLE = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_RD   = 2'b10;

  // Default parameter values
  localparam int DEF_FIFO_DEPTH     = 4;
  localparam int DEF_TWR_CYCLES     = 250000;
  localparam int DEF_TIMEOUT_CYCLES = 1000000;

  // One queued command: rw = 1 means byte read
  typedef struct packed {
    logic       rw;
    logic [7:0] addr;
    logic [7:0] data;
  } cmd_t;

  localparam int CMD_W = 17;

  // Counter width for a cycle count, never narrower than one bit
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/eeprom_cmd_seq_if.sv
// Command/response bus between a requester and the EEPROM sequencer.
// Latency: none, wires only.
// Backpressure: Cmd_Ready stalls Cmd_Valid; responses are unthrottled pulses.
interface eeprom_cmd_seq_if;
  logic       Cmd_Valid;
  logic       Cmd_Ready;
  logic       Cmd_Rw;
  logic [7:0] Cmd_Addr;
  logic [7:0] Cmd_Data;
  logic       Rsp_Valid;
  logic [7:0] Rsp_Data;
  logic [7:0] Rsp_Addr;
  logic       Rsp_Err;

  // Requester side
  modport master (
    output Cmd_Valid, Cmd_Rw, Cmd_Addr, Cmd_Data,
    input  Cmd_Ready, Rsp_Valid, Rsp_Data, Rsp_Addr, Rsp_Err
  );

  // Sequencer side
  modport slave (
    input  Cmd_Valid, Cmd_Rw, Cmd_Addr, Cmd_Data,
    output Cmd_Ready, Rsp_Valid, Rsp_Data, Rsp_Addr, Rsp_Err
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-bit pointers for full/empty detection.
// Latency: pushed entry visible at pop_dat one cycle after the push edge.
// Backpressure: pushes while full and pops while empty are dropped.
module sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_vld,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push_vld && !full;
  assign do_pop  = pop_vld && !empty;
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  // Pointers wrap naturally modulo DEPTH; the top bit tells full from empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; empty pointers make stale contents unreachable
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/eeprom_cmd_seq.sv
// Queues EEPROM byte read/write commands and sequences them onto an I2C engine.
// Latency: head issued 1 cycle after reaching IDLE; read response 1 cycle after Done_Sig.
// Backpressure: Cmd_Ready drops while the command FIFO is full.
module eeprom_cmd_seq
  import eeprom_pkg::*;
#(
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int TWR_CYCLES     = DEF_TWR_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  eeprom_cmd_seq_if.slave      cmd_bus,
  output logic                 Busy,
  output logic [1:0]           Start_Sig,
  output logic [7:0]           Addr_Sig,
  output logic [7:0]           WrData,
  input  logic [7:0]           RdData,
  input  logic                 Done_Sig
);

  localparam int TWR_W = cnt_w(TWR_CYCLES);
  localparam int TO_W  = cnt_w(TIMEOUT_CYCLES);
  localparam logic [TWR_W-1:0] TWR_LAST = TWR_W'(TWR_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  cmd_t             push_cmd;
  cmd_t             head_cmd;
  logic             push_vld;
  logic             pop_vld;
  logic             fifo_full;
  logic             fifo_empty;
  logic             rdy_en;
  state_t           state;
  logic             op_rd;
  logic             timed_out;
  logic [TWR_W-1:0] twr_cnt;
  logic [TO_W-1:0]  to_cnt;

  assign push_cmd          = '{rw: cmd_bus.Cmd_Rw, addr: cmd_bus.Cmd_Addr, data: cmd_bus.Cmd_Data};
  assign cmd_bus.Cmd_Ready = rdy_en && !fifo_full;
  assign push_vld          = cmd_bus.Cmd_Valid && cmd_bus.Cmd_Ready;
  assign pop_vld           = (state == ST_IDLE) && !fifo_empty;
  assign Busy              = !fifo_empty || (state != ST_IDLE);

  sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (CLK),
    .rst_n    (RSTn),
    .push_vld (push_vld),
    .push_dat (push_cmd),
    .pop_vld  (pop_vld),
    .pop_dat  (head_cmd),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Hold Cmd_Ready low through reset and until the first edge after release
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) rdy_en <= 1'b0;
    else       rdy_en <= 1'b1;
  end

  // Sequencer: issue head command, wait for Done_Sig or timeout, release, write-cycle wait
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state             <= ST_IDLE;
      Start_Sig         <= OP_IDLE;
      Addr_Sig          <= 8'h00;
      WrData            <= 8'h00;
      op_rd             <= 1'b0;
      timed_out         <= 1'b0;
      twr_cnt           <= '0;
      to_cnt            <= '0;
      cmd_bus.Rsp_Valid <= 1'b0;
      cmd_bus.Rsp_Err   <= 1'b0;
      cmd_bus.Rsp_Data  <= 8'h00;
      cmd_bus.Rsp_Addr  <= 8'h00;
    end else begin
      cmd_bus.Rsp_Valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            Addr_Sig  <= head_cmd.addr;
            WrData    <= head_cmd.data;
            op_rd     <= head_cmd.rw;
            Start_Sig <= head_cmd.rw ? OP_RD : OP_WR;
            to_cnt    <= '0;
            timed_out <= 1'b0;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (Done_Sig) begin
            Start_Sig <= OP_IDLE;
            state     <= ST_RELEASE;
            if (op_rd) begin
              cmd_bus.Rsp_Valid <= 1'b1;
              cmd_bus.Rsp_Err   <= 1'b0;
              cmd_bus.Rsp_Data  <= RdData;
              cmd_bus.Rsp_Addr  <= Addr_Sig;
            end
          end else if (to_cnt == TO_LAST) begin
            // Engine never answered: report the address, keep the last read byte
            Start_Sig         <= OP_IDLE;
            state             <= ST_RELEASE;
            timed_out         <= 1'b1;
            cmd_bus.Rsp_Valid <= 1'b1;
            cmd_bus.Rsp_Err   <= 1'b1;
            cmd_bus.Rsp_Addr  <= Addr_Sig;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          twr_cnt <= '0;
          // Only a completed write needs the EEPROM internal write time
          state   <= (!op_rd && !timed_out) ? ST_TWR_WAIT : ST_IDLE;
        end
        ST_TWR_WAIT: begin
          if (twr_cnt == TWR_LAST) state <= ST_IDLE;
          else                     twr_cnt <= twr_cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eeprom_cmd_seq.sv
// Randomized scoreboard bench for eeprom_cmd_seq with a behavioural I2C engine.
// Latency: n/a.
// Backpressure: stimulus honours Cmd_Ready.
module tb_eeprom_cmd_seq;
  import eeprom_pkg::*;

  localparam int TWR = 20;
  localparam int TMO = 50;

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic       Busy;
  logic [1:0] Start_Sig;
  logic [7:0] Addr_Sig;
  logic [7:0] WrData;
  logic [7:0] RdData;
  logic       Done_Sig;

  always #5 CLK = ~CLK;

  eeprom_cmd_seq_if cmd_bus();

  eeprom_cmd_seq #(
    .FIFO_DEPTH     (4),
    .TWR_CYCLES     (TWR),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .cmd_bus   (cmd_bus),
    .Busy      (Busy),
    .Start_Sig (Start_Sig),
    .Addr_Sig  (Addr_Sig),
    .WrData    (WrData),
    .RdData    (RdData),
    .Done_Sig  (Done_Sig)
  );

  typedef struct {
    logic       rw;
    logic [7:0] addr;
    logic [7:0] data;
    bit         hang;
  } iss_t;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       err;
  } rsp_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  iss_t exp_iss[$];
  rsp_t exp_rsp[$];
  logic [7:0] exp_last = 8'h00;
  logic [7:0] eep[256];
  logic [7:0] ref_mem[256];
  bit   hang_en = 1'b0;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: commands execute in acceptance order against a flat byte array
  task automatic model_accept(input logic rw, input logic [7:0] a, input logic [7:0] d);
    bit h;
    h = hang_en && rw && (a == 8'h7F);
    exp_iss.push_back('{rw: rw, addr: a, data: d, hang: h});
    if (!rw)    ref_mem[a] = d;
    else if (h) exp_rsp.push_back('{addr: a, data: 8'h00, err: 1'b1});
    else        exp_rsp.push_back('{addr: a, data: ref_mem[a], err: 1'b0});
  endtask

  // I2C engine: random completion latency, optional hang on reads of 0x7F,
  // and stray Done_Sig pulses whenever no transaction is offered
  int eng_cnt;
  int eng_lat;
  initial begin
    Done_Sig = 1'b0;
    RdData   = 8'h00;
    eng_cnt  = 0;
    eng_lat  = 1;
    forever begin
      @(posedge CLK); #1;
      Done_Sig = 1'b0;
      RdData   = 8'($urandom);
      if (Start_Sig == 2'b00) begin
        eng_cnt = 0;
        if ($urandom_range(0, 7) == 0) Done_Sig = 1'b1;
      end else if (!(hang_en && Start_Sig == 2'b10 && Addr_Sig == 8'h7F)) begin
        if (eng_cnt == 0) eng_lat = $urandom_range(1, 6);
        eng_cnt++;
        if (eng_cnt >= eng_lat) begin
          Done_Sig = 1'b1;
          eng_cnt  = 0;
          if (Start_Sig == 2'b01) eep[Addr_Sig] = WrData;
          else                    RdData = eep[Addr_Sig];
        end
      end
    end
  end

  // Monitor: pops expected responses and issues as the DUT presents them
  logic [1:0] prev_start = 2'b00;
  int         zero_run = 1000;
  int         dur = 0;
  bit         held = 1'b1;
  bit         last_wr = 1'b0;
  iss_t       cur;
  logic [1:0] hold_start;
  logic [7:0] hold_addr;
  logic [7:0] hold_data;
  rsp_t       er;
  initial begin
    cur = '{rw: 1'b0, addr: 8'h00, data: 8'h00, hang: 1'b0};
    forever begin
      @(negedge CLK);
      if (!RSTn) begin
        prev_start = 2'b00;
        zero_run   = 1000;
        if (cmd_bus.Rsp_Valid) chk(1'b0, "rsp_in_reset", 1, 0);
      end else begin
        if (cmd_bus.Rsp_Valid) begin
          if (exp_rsp.size() == 0) begin
            chk(1'b0, "unexpected_rsp", cmd_bus.Rsp_Addr, 0);
          end else begin
            er = exp_rsp.pop_front();
            chk(cmd_bus.Rsp_Err == er.err, "rsp_err", cmd_bus.Rsp_Err, er.err);
            chk(cmd_bus.Rsp_Addr == er.addr, "rsp_addr", cmd_bus.Rsp_Addr, er.addr);
            if (!er.err) exp_last = er.data;
            chk(cmd_bus.Rsp_Data == exp_last, "rsp_data", cmd_bus.Rsp_Data, exp_last);
          end
        end
        if (prev_start == 2'b00 && Start_Sig != 2'b00) begin
          if (exp_iss.size() == 0) begin
            chk(1'b0, "unexpected_issue", Start_Sig, 0);
          end else begin
            cur = exp_iss.pop_front();
            chk(Start_Sig == (cur.rw ? 2'b10 : 2'b01), "issue_op", Start_Sig, cur.rw ? 2 : 1);
            chk(Addr_Sig == cur.addr, "issue_addr", Addr_Sig, cur.addr);
            if (!cur.rw) chk(WrData == cur.data, "issue_wrdata", WrData, cur.data);
            chk(zero_run >= (last_wr ? TWR + 1 : 2), "idle_gap", zero_run, last_wr ? TWR + 1 : 2);
          end
          held       = 1'b1;
          dur        = 0;
          hold_start = Start_Sig;
          hold_addr  = Addr_Sig;
          hold_data  = WrData;
        end
        if (Start_Sig != 2'b00) begin
          dur++;
          zero_run = 0;
          if (Start_Sig != hold_start || Addr_Sig != hold_addr || WrData != hold_data) held = 1'b0;
        end
        if (prev_start != 2'b00 && Start_Sig == 2'b00) begin
          chk(held, "issue_hold", held, 1);
          if (cur.hang) chk(dur == TMO, "timeout_len", dur, TMO);
          last_wr = !cur.rw;
        end
        if (Start_Sig == 2'b00) zero_run++;
        prev_start = Start_Sig;
      end
    end
  end

  // Offer one command (called at a negedge) and wait for it to be taken
  task automatic push_cmd(input logic rw, input logic [7:0] a, input logic [7:0] d);
    int n;
    n = 0;
    cmd_bus.Cmd_Valid = 1'b1;
    cmd_bus.Cmd_Rw    = rw;
    cmd_bus.Cmd_Addr  = a;
    cmd_bus.Cmd_Data  = rw ? 8'($urandom) : d;
    while (!cmd_bus.Cmd_Ready && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    if (!cmd_bus.Cmd_Ready) begin
      chk(1'b0, "accept_timeout", n, 3000);
      cmd_bus.Cmd_Valid = 1'b0;
    end else begin
      @(posedge CLK);
      model_accept(rw, a, d);
      @(negedge CLK);
    end
  endtask

  task automatic idle_bus();
    cmd_bus.Cmd_Valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((Busy || exp_rsp.size() != 0) && n < 5000) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 5000) chk(1'b0, "idle_timeout", n, 5000);
    repeat (3) @(negedge CLK);
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    while (Start_Sig == 2'b00 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 200) chk(1'b0, "start_timeout", n, 200);
  endtask

  task automatic rand_batch(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        idle_bus();
        repeat ($urandom_range(1, 30)) @(negedge CLK);
      end
      push_cmd(1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom));
    end
    idle_bus();
  endtask

  initial begin
    repeat (60000) @(posedge CLK);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  initial begin
    bit         saw_rdy;
    logic [7:0] v;
    cmd_bus.Cmd_Valid = 1'b0;
    cmd_bus.Cmd_Rw    = 1'b0;
    cmd_bus.Cmd_Addr  = 8'h00;
    cmd_bus.Cmd_Data  = 8'h00;
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      eep[i]     = v;
      ref_mem[i] = v;
    end

    // Reset state
    RSTn = 1'b0;
    repeat (3) @(negedge CLK);
    chk(Start_Sig == 2'b00, "rst_start", Start_Sig, 0);
    chk(Addr_Sig == 8'h00, "rst_addr_sig", Addr_Sig, 0);
    chk(WrData == 8'h00, "rst_wrdata", WrData, 0);
    chk(cmd_bus.Rsp_Data == 8'h00, "rst_rsp_data", cmd_bus.Rsp_Data, 0);
    chk(cmd_bus.Rsp_Addr == 8'h00, "rst_rsp_addr", cmd_bus.Rsp_Addr, 0);
    chk(cmd_bus.Rsp_Valid == 1'b0, "rst_rsp_valid", cmd_bus.Rsp_Valid, 0);
    chk(cmd_bus.Rsp_Err == 1'b0, "rst_rsp_err", cmd_bus.Rsp_Err, 0);
    chk(Busy == 1'b0, "rst_busy", Busy, 0);
    chk(cmd_bus.Cmd_Ready == 1'b0, "rst_cmd_ready", cmd_bus.Cmd_Ready, 0);
    RSTn = 1'b1;
    @(negedge CLK);
    chk(cmd_bus.Cmd_Ready == 1'b1, "ready_after_rst", cmd_bus.Cmd_Ready, 1);

    // Single write, then write followed by read-back
    push_cmd(1'b0, 8'h00, 8'h12);
    idle_bus();
    wait_idle();
    push_cmd(1'b0, 8'h00, 8'h12);
    push_cmd(1'b1, 8'h00, 8'h00);
    idle_bus();
    wait_idle();

    rand_batch(40);
    wait_idle();

    // Hung read holds the sequencer while the FIFO fills behind it
    hang_en = 1'b1;
    push_cmd(1'b1, 8'h7F, 8'h00);
    idle_bus();
    wait_start();
    for (int i = 0; i < 4; i++) push_cmd(1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom));
    chk(cmd_bus.Cmd_Ready == 1'b0, "ready_full", cmd_bus.Cmd_Ready, 0);
    saw_rdy = 1'b0;
    repeat (10) begin
      @(negedge CLK);
      if (cmd_bus.Cmd_Ready) saw_rdy = 1'b1;
    end
    chk(!saw_rdy, "ready_stays_low", saw_rdy, 0);
    push_cmd(1'b0, 8'h09, 8'hA5);
    push_cmd(1'b1, 8'h09, 8'h00);
    idle_bus();
    wait_idle();

    // Reset in the middle of a hung read with two reads queued
    push_cmd(1'b1, 8'h7F, 8'h00);
    push_cmd(1'b1, 8'($urandom_range(0, 15)), 8'h00);
    push_cmd(1'b1, 8'($urandom_range(0, 15)), 8'h00);
    idle_bus();
    wait_start();
    repeat (5) @(negedge CLK);
    RSTn = 1'b0;
    #1;
    chk(Start_Sig == 2'b00, "midrst_start", Start_Sig, 0);
    chk(Busy == 1'b0, "midrst_busy", Busy, 0);
    chk(cmd_bus.Rsp_Valid == 1'b0, "midrst_rsp_valid", cmd_bus.Rsp_Valid, 0);
    exp_iss.delete();
    exp_rsp.delete();
    exp_last = 8'h00;
    repeat (3) @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
    chk(cmd_bus.Cmd_Ready == 1'b1, "ready_after_midrst", cmd_bus.Cmd_Ready, 1);
    repeat (40) @(negedge CLK);
    chk(Busy == 1'b0, "busy_after_midrst", Busy, 0);
    hang_en = 1'b0;
    push_cmd(1'b1, 8'h03, 8'h00);
    idle_bus();
    wait_idle();
    rand_batch(15);
    wait_idle();

    chk(exp_iss.size() == 0, "issue_q_drained", exp_iss.size(), 0);
    chk(exp_rsp.size() == 0, "rsp_q_drained", exp_rsp.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
